// File: rtl/mysopc_nios2_ocimem_ctrl_if.sv
// Bus bundle between the JTAG sysclk stage / CPU debug slave and the OCI monitor RAM controller.
// The controller uses the slave modport; whoever drives jdo/take_* and the avs_* strobes uses master.
interface mysopc_nios2_ocimem_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_no_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              debugack;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;

  modport slave (
    input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b, debugack,
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest, MonDReg, monitor_ready, monitor_error
  );

  modport master (
    output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b, debugack,
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest, MonDReg, monitor_ready, monitor_error
  );
endinterface

// File: rtl/mysopc_nios2_ocimem_ctrl.sv
// OCI debug monitor RAM controller: shares one RAM port between the JTAG host and the CPU slave (CPU first).
// Define MYSOPC_OCIMEM_WRPROTECT_EN to write-protect the lowest WP_WORDS words.
module mysopc_nios2_ocimem_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int WP_WORDS  = 32
) (
  input logic                       clk,
  input logic                       reset,
  mysopc_nios2_ocimem_ctrl_if.slave bus
);

`ifdef MYSOPC_OCIMEM_WRPROTECT_EN
  localparam bit WpEnable = 1'b1;
`else
  localparam bit WpEnable = 1'b0;
`endif
  localparam logic [ADDR_W:0] DepthLim = MEM_DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] WpLim    = WP_WORDS[ADDR_W:0];

  typedef enum logic [1:0] {IDLE, JRD_ISSUE, JRD_DATA, JWR} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_monAReg;
  logic [ADDR_W-1:0] r_opAddr;
  logic [31:0]       r_opData;
  logic [31:0]       r_monDReg;
  logic [31:0]       r_ramQ;
  logic              r_pend;
  logic              r_pendWr;
  logic              r_opBad;
  logic              r_ready;
  logic              r_error;
  logic              r_cpuRdDone;
  logic              r_cpuRdOk;
  logic [31:0]       r_mem [0:MEM_DEPTH-1];

  logic              w_cpuBusy;
  logic              w_busy;
  logic              w_anyTake;
  logic              w_accept;
  logic              w_drop;
  logic [ADDR_W-1:0] w_jdoAddr;
  logic [ADDR_W-1:0] w_nextAddr;
  logic              w_cpuWe;
  logic              w_jtagWe;
  logic              w_ramWe;
  logic [ADDR_W-1:0] w_ramAddr;
  logic [31:0]       w_ramWdata;
  logic              w_opErr;
  logic              w_errClr;
  logic              w_unusedJdo;

  function automatic logic inRange(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DepthLim;
  endfunction

  function automatic logic wrProt(input logic [ADDR_W-1:0] a);
    return WpEnable && ({1'b0, a} < WpLim);
  endfunction

  assign w_cpuBusy  = bus.avs_read | bus.avs_write;
  assign w_busy     = r_pend | (r_state != IDLE);
  assign w_anyTake  = bus.take_action_ocimem_a | bus.take_no_action_ocimem_a | bus.take_action_ocimem_b;
  assign w_accept   = w_anyTake & ~w_busy;
  assign w_drop     = w_anyTake & w_busy;
  assign w_jdoAddr  = bus.jdo[ADDR_W+1:2];
  assign w_nextAddr = r_monAReg + 1'b1;
  assign w_unusedJdo = ^{bus.jdo[37:36], bus.jdo[1:0]};

  // JTAG only reaches the RAM in cycles where the CPU is not strobing.
  assign w_cpuWe    = bus.avs_write & inRange(bus.avs_address) & ~wrProt(bus.avs_address);
  assign w_jtagWe   = (r_state == JWR) & ~w_cpuBusy & ~r_opBad;
  assign w_ramWe    = w_cpuWe | w_jtagWe;
  assign w_ramAddr  = w_cpuBusy ? bus.avs_address : r_opAddr;
  assign w_ramWdata = w_cpuBusy ? bus.avs_writedata : r_opData;

  assign w_opErr  = r_opBad & ((r_state == JRD_DATA) | ((r_state == JWR) & ~w_cpuBusy));
  assign w_errClr = w_accept & bus.take_action_ocimem_a & bus.jdo[34];

  always_ff @(posedge clk) begin
    if (w_ramWe) r_mem[w_ramAddr] <= w_ramWdata;
    r_ramQ <= r_mem[w_ramAddr];
  end

  // Accepted pulses snapshot their target address/data so later increments cannot disturb them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_monAReg   <= '0;
      r_opAddr    <= '0;
      r_opData    <= '0;
      r_monDReg   <= '0;
      r_pend      <= 1'b0;
      r_pendWr    <= 1'b0;
      r_opBad     <= 1'b0;
      r_ready     <= 1'b1;
      r_error     <= 1'b0;
      r_cpuRdDone <= 1'b0;
      r_cpuRdOk   <= 1'b0;
    end else begin
      r_cpuRdDone <= bus.avs_read & ~r_cpuRdDone;
      r_cpuRdOk   <= inRange(bus.avs_address);
      r_error     <= (r_error & ~w_errClr) | w_drop | w_opErr;

      if (w_accept) begin
        if (bus.take_action_ocimem_a) begin
          r_monAReg <= w_jdoAddr;
          r_opAddr  <= w_jdoAddr;
          r_pend    <= bus.jdo[35];
          r_pendWr  <= 1'b0;
          r_opBad   <= ~inRange(w_jdoAddr);
          if (bus.jdo[35]) r_ready <= 1'b0;
        end else if (bus.take_no_action_ocimem_a) begin
          r_monAReg <= w_nextAddr;
          r_opAddr  <= w_nextAddr;
          r_pend    <= 1'b1;
          r_pendWr  <= 1'b0;
          r_opBad   <= ~inRange(w_nextAddr);
          r_ready   <= 1'b0;
        end else begin
          r_monAReg <= w_nextAddr;
          r_opAddr  <= r_monAReg;
          r_opData  <= bus.jdo[34:3];
          r_pend    <= 1'b1;
          r_pendWr  <= 1'b1;
          r_opBad   <= ~bus.debugack | ~inRange(r_monAReg) | wrProt(r_monAReg);
          r_ready   <= 1'b0;
        end
      end

      unique case (r_state)
        IDLE: begin
          if (r_pend && !w_cpuBusy) begin
            r_pend  <= 1'b0;
            r_state <= r_pendWr ? JWR : JRD_ISSUE;
          end
        end
        JRD_ISSUE: begin
          if (!w_cpuBusy) r_state <= JRD_DATA;
        end
        JRD_DATA: begin
          r_monDReg <= r_opBad ? 32'hDEADBEEF : r_ramQ;
          r_ready   <= 1'b1;
          r_state   <= IDLE;
        end
        JWR: begin
          if (!w_cpuBusy) begin
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.avs_waitrequest = bus.avs_read & ~r_cpuRdDone;
  assign bus.avs_readdata    = (r_cpuRdDone && r_cpuRdOk) ? r_ramQ : 32'h0;
  assign bus.MonDReg         = r_monDReg;
  assign bus.monitor_ready   = r_ready;
  assign bus.monitor_error   = r_error;

endmodule

// File: tb/tb_mysopc_nios2_ocimem_ctrl.sv
// Scoreboard bench for mysopc_nios2_ocimem_ctrl: stimulus pushes expectations, a negedge monitor pops them.
// Expectations follow MYSOPC_OCIMEM_WRPROTECT_EN when it is defined for the build.
module tb_mysopc_nios2_ocimem_ctrl;
  localparam int ADDR_W    = 8;
  localparam int MEM_DEPTH = 200;
  localparam int WP_WORDS  = 4;
`ifdef MYSOPC_OCIMEM_WRPROTECT_EN
  localparam bit WpOn = 1'b1;
`else
  localparam bit WpOn = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    bit          chkData;
    bit          err;
    string       name;
  } jtagExp_t;

  typedef struct {
    logic [31:0] data;
    string       name;
  } cpuExp_t;

  logic     clk = 1'b0;
  logic     reset;
  jtagExp_t jtagQ[$];
  cpuExp_t  cpuQ[$];
  int       checks = 0;
  int       errors = 0;
  logic     prevReady;
  int       n;

  always #5 clk = ~clk;

  mysopc_nios2_ocimem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mysopc_nios2_ocimem_ctrl #(
    .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .WP_WORDS(WP_WORDS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ta, input logic tna, input logic tb, input logic [37:0] jdoVal);
    bus.jdo                     = jdoVal;
    bus.take_action_ocimem_a    = ta;
    bus.take_no_action_ocimem_a = tna;
    bus.take_action_ocimem_b    = tb;
    tick();
    bus.take_action_ocimem_a    = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b    = 1'b0;
  endtask

  function automatic logic [37:0] addrJdo(input logic rd, input logic clr, input logic [ADDR_W-1:0] addr);
    logic [37:0] v;
    v = '0;
    v[35] = rd;
    v[34] = clr;
    v[ADDR_W+1:2] = addr;
    return v;
  endfunction

  function automatic logic [37:0] dataJdo(input logic [31:0] d);
    logic [37:0] v;
    v = '0;
    v[34:3] = d;
    return v;
  endfunction

  task automatic jtagLoad(input logic [ADDR_W-1:0] addr, input logic rd, input logic clr);
    applyStimulus(1'b1, 1'b0, 1'b0, addrJdo(rd, clr, addr));
  endtask

  task automatic pushJ(input logic [31:0] d, input bit chk, input bit e, input string nm);
    jtagExp_t x;
    x.data = d; x.chkData = chk; x.err = e; x.name = nm;
    jtagQ.push_back(x);
  endtask

  task automatic pushC(input logic [31:0] d, input string nm);
    cpuExp_t x;
    x.data = d; x.name = nm;
    cpuQ.push_back(x);
  endtask

  task automatic waitReady(output int cyc);
    cyc = 0;
    while (bus.monitor_ready !== 1'b1 && cyc < 50) begin
      tick();
      cyc++;
    end
    if (bus.monitor_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL readyTimeout: got %b expected 1 within 50 cycles", bus.monitor_ready);
    end
  endtask

  task automatic cpuRead(input logic [ADDR_W-1:0] addr);
    int k;
    k = 0;
    bus.avs_address = addr;
    bus.avs_read    = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (bus.avs_waitrequest && k < 10);
    if (bus.avs_waitrequest) begin
      checks++;
      errors++;
      $display("[TB] FAIL cpuReadTimeout: waitrequest got 1 expected 0 within 10 cycles");
    end
    tick();
    bus.avs_read = 1'b0;
  endtask

  task automatic cpuWrite(input logic [ADDR_W-1:0] addr, input logic [31:0] d);
    bus.avs_address   = addr;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    tick();
    bus.avs_write = 1'b0;
  endtask

  // Monitor: a rising monitor_ready completes one JTAG op; an unstalled avs_read completes one CPU read.
  always @(negedge clk) begin : monitor
    jtagExp_t je;
    cpuExp_t  ce;
    if (reset) begin
      prevReady = 1'b1;
    end else begin
      if (bus.monitor_ready === 1'b1 && prevReady !== 1'b1) begin
        if (jtagQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL jtagUnexpected: got completion with MonDReg %h expected none", bus.MonDReg);
        end else begin
          je = jtagQ.pop_front();
          if (je.chkData) checkOutput({je.name, ".data"}, bus.MonDReg, je.data);
          checkOutput({je.name, ".err"}, {31'b0, bus.monitor_error}, {31'b0, je.err});
        end
      end
      prevReady = bus.monitor_ready;
      if (bus.avs_read === 1'b1 && bus.avs_waitrequest === 1'b0) begin
        if (cpuQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL cpuUnexpected: got readdata %h expected none", bus.avs_readdata);
        end else begin
          ce = cpuQ.pop_front();
          checkOutput(ce.name, bus.avs_readdata, ce.data);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 300000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.jdo = '0;
    bus.take_action_ocimem_a = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b = 1'b0;
    bus.debugack = 1'b1;
    bus.avs_address = '0;
    bus.avs_read = 1'b0;
    bus.avs_write = 1'b0;
    bus.avs_writedata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    checkOutput("reset.MonDReg", bus.MonDReg, 32'h0);
    checkOutput("reset.ready", {31'b0, bus.monitor_ready}, 32'h1);
    checkOutput("reset.error", {31'b0, bus.monitor_error}, 32'h0);
    checkOutput("reset.wait", {31'b0, bus.avs_waitrequest}, 32'h0);
    checkOutput("reset.readdata", bus.avs_readdata, 32'h0);

    // Write 5, write 6 (proves post-increment), then read 5 back with its latency.
    jtagLoad(8'd5, 1'b0, 1'b0);
    pushJ(32'h0, 1'b1, 1'b0, "t2.wr5");
    applyStimulus(1'b0, 1'b0, 1'b1, dataJdo(32'h12345678));
    waitReady(n);
    pushJ(32'h0, 1'b1, 1'b0, "t2.wr6");
    applyStimulus(1'b0, 1'b0, 1'b1, dataJdo(32'h66666666));
    waitReady(n);
    pushC(32'h66666666, "t2.cpuRd6");
    cpuRead(8'd6);
    pushJ(32'h12345678, 1'b1, 1'b0, "t2.rd5");
    jtagLoad(8'd5, 1'b1, 1'b0);
    waitReady(n);
    checkOutput("t2.rdLatency", n, 32'd3);

    // CPU read of word 5 issued in the same cycle as a JTAG read of word 5.
    pushC(32'h12345678, "t3.cpuRd5");
    pushJ(32'h12345678, 1'b1, 1'b0, "t3.jtagRd5");
    bus.avs_address = 8'd5;
    bus.avs_read = 1'b1;
    bus.jdo = addrJdo(1'b1, 1'b0, 8'd5);
    bus.take_action_ocimem_a = 1'b1;
    #1 checkOutput("t3.cpuWait", {31'b0, bus.avs_waitrequest}, 32'h1);
    tick();
    bus.take_action_ocimem_a = 1'b0;
    tick();
    bus.avs_read = 1'b0;
    waitReady(n);
    checkOutput("t3.jtagLatency", n + 1, 32'd4);

    // A pulse arriving while a read is pending is dropped and flags an error.
    pushJ(32'h12345678, 1'b1, 1'b1, "drop.rd5");
    jtagLoad(8'd5, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    waitReady(n);
    jtagLoad(8'd64, 1'b0, 1'b1);
    checkOutput("drop.errClear", {31'b0, bus.monitor_error}, 32'h0);

    // JTAG write without debugack: RAM untouched, error set, address still advances.
    cpuWrite(8'd7, 32'h77777777);
    bus.debugack = 1'b0;
    jtagLoad(8'd7, 1'b0, 1'b0);
    pushJ(32'h12345678, 1'b1, 1'b1, "t4.wrNoAck");
    applyStimulus(1'b0, 1'b0, 1'b1, dataJdo(32'hBAD0BAD0));
    waitReady(n);
    pushC(32'h77777777, "t4.cpuRd7");
    cpuRead(8'd7);
    bus.debugack = 1'b1;
    pushJ(32'h12345678, 1'b1, 1'b1, "t4.wr8");
    applyStimulus(1'b0, 1'b0, 1'b1, dataJdo(32'hAAAA0008));
    waitReady(n);
    pushC(32'hAAAA0008, "t4.cpuRd8");
    cpuRead(8'd8);
    jtagLoad(8'd0, 1'b0, 1'b1);
    checkOutput("t4.errClear", {31'b0, bus.monitor_error}, 32'h0);

    // Out-of-range CPU access reads zero, writes nothing, leaves the error flag alone.
    cpuWrite(8'd210, 32'hFFFFFFFF);
    pushC(32'h0, "cpuOor.rd210");
    cpuRead(8'd210);
    checkOutput("cpuOor.error", {31'b0, bus.monitor_error}, 32'h0);

    // CPU and JTAG write word 10 in the same cycle; the JTAG value must end up in RAM.
    jtagLoad(8'd10, 1'b0, 1'b0);
    pushJ(32'h12345678, 1'b1, 1'b0, "t7.jwr10");
    bus.avs_address = 8'd10;
    bus.avs_writedata = 32'h22220000;
    bus.avs_write = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, dataJdo(32'h11110000));
    bus.avs_write = 1'b0;
    waitReady(n);
    pushC(32'h11110000, "t7.cpuRd10");
    cpuRead(8'd10);

    // Address 255 wraps to word 0; address 220 is beyond the 200-word RAM.
    cpuWrite(8'd0, 32'h0000C0DE);
    jtagLoad(8'd255, 1'b0, 1'b0);
    pushJ(32'h0000C0DE, !WpOn, 1'b0, "t5.wrapRd0");
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    waitReady(n);
    pushJ(32'hDEADBEEF, 1'b1, 1'b1, "t5.oorRd220");
    jtagLoad(8'd220, 1'b1, 1'b0);
    waitReady(n);
    jtagLoad(8'd0, 1'b0, 1'b1);
    checkOutput("t5.errClear", {31'b0, bus.monitor_error}, 32'h0);

    // Low word 3 is writable unless write protection is built in.
    jtagLoad(8'd3, 1'b0, 1'b0);
    pushJ(32'hDEADBEEF, 1'b1, WpOn, "t6.wr3");
    applyStimulus(1'b0, 1'b0, 1'b1, dataJdo(32'h33333333));
    waitReady(n);
    if (!WpOn) begin
      pushC(32'h33333333, "t6.cpuRd3");
      cpuRead(8'd3);
    end

    // Reset in the middle of a read abandons it; the next read runs normally.
    jtagLoad(8'd5, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("rst.ready", {31'b0, bus.monitor_ready}, 32'h1);
    checkOutput("rst.MonDReg", bus.MonDReg, 32'h0);
    pushJ(32'h12345678, 1'b1, 1'b0, "rst.rd5");
    jtagLoad(8'd5, 1'b1, 1'b0);
    waitReady(n);
    checkOutput("rst.rdLatency", n, 32'd3);

    repeat (4) tick();
    checkOutput("jtagQ.drained", jtagQ.size(), 32'd0);
    checkOutput("cpuQ.drained", cpuQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
